// File: rtl/nibble_stream_sorter.sv
`default_nettype none
// ============================================================================
// Module      : nibble_stream_sorter
// Description : Loads N W-bit elements over a valid/ready stream, bubble-sorts
//               them ascending (one compare-exchange per clock), then streams
//               them out with a last marker on the final beat.
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_stream_sorter #(
    parameter int W = 4,
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_last,
    output logic         busy
);

    localparam int              c_AW    = (N > 2) ? $clog2(N) : 1;
    localparam logic [c_AW-1:0] c_ONE   = c_AW'(1);
    localparam logic [c_AW-1:0] c_LAST  = c_AW'(N - 1);
    localparam logic [1:0]      c_LOAD  = 2'd0;
    localparam logic [1:0]      c_SORT  = 2'd1;
    localparam logic [1:0]      c_DRAIN = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [W-1:0]    mem_q [N];
    logic [W-1:0]    mem_d [N];
    logic [c_AW-1:0] wr_q, wr_d, rd_q, rd_d, a_q, a_d, b_q, b_d;

    logic [c_AW-1:0] w_b_nxt;
    logic            w_swap;
    logic            w_b_more;
    logic            w_a_more;
    logic            w_sort_done;

    // b only ranges up to a-1 <= N-2 during SORT, so b+1 stays in bounds
    assign w_b_nxt     = b_q + c_ONE;
    assign w_swap      = mem_q[w_b_nxt] < mem_q[b_q];
    assign w_b_more    = b_q < (a_q - c_ONE);
    assign w_a_more    = a_q > c_ONE;
    assign w_sort_done = !w_b_more && !w_a_more;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= c_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_LOAD:  if (in_valid && wr_q == c_LAST)   state_d = c_SORT;
            c_SORT:  if (w_sort_done)                  state_d = c_DRAIN;
            c_DRAIN: if (out_ready && rd_q == c_LAST)  state_d = c_LOAD;
            default:                                   state_d = c_LOAD;
        endcase
    end

    always_comb begin
        in_ready  = !rst && (state_q == c_LOAD);
        out_valid = !rst && (state_q == c_DRAIN);
        busy      = !rst && (state_q != c_LOAD);
        out_data  = out_valid ? mem_q[rd_q] : '0;
        out_last  = out_valid && (rd_q == c_LAST);
    end

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        a_d   = a_q;
        b_d   = b_q;
        case (state_q)
            c_LOAD: begin
                if (in_valid) begin
                    mem_d[wr_q] = in_data;
                    if (wr_q == c_LAST) begin
                        wr_d = '0;
                        a_d  = c_LAST;
                        b_d  = '0;
                    end else begin
                        wr_d = wr_q + c_ONE;
                    end
                end
            end
            c_SORT: begin
                if (w_swap) begin
                    mem_d[b_q]     = mem_q[w_b_nxt];
                    mem_d[w_b_nxt] = mem_q[b_q];
                end
                if (w_b_more) begin
                    b_d = w_b_nxt;
                end else if (w_a_more) begin
                    a_d = a_q - c_ONE;
                    b_d = '0;
                end else begin
                    rd_d = '0;
                end
            end
            c_DRAIN: begin
                if (out_ready) begin
                    rd_d = (rd_q == c_LAST) ? '0 : rd_q + c_ONE;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                mem_q[i] <= '0;
            end
            wr_q <= '0;
            rd_q <= '0;
            a_q  <= c_LAST;
            b_q  <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            a_q   <= a_d;
            b_q   <= b_d;
        end
    end

endmodule
`default_nettype wire
